// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: register bank with valid/ready request/response channels,
// byte-strobed writes, registered reads and a saturating error counter.
module reg_bank_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 7,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [IDX_W-1:0] idx;
  logic accept, fire, in_range;
  assign idx       = req_addr[IDX_W-1:0];
  assign in_range  = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign req_ready = rst_n & ((state == IDLE) | rsp_ready);
  assign accept    = req_valid & req_ready;
  assign rsp_valid = state == RESP;
  assign fire      = rsp_valid & rsp_ready;
  always_comb state_nx = accept ? RESP : fire ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (accept & req_wr & in_range) begin
      for (int k = 0; k < DATA_W/8; k++)
        if (req_wstrb[k]) regs[idx][8*k +: 8] <= req_wdata[8*k +: 8];
    end
  // The read returns the pre-edge register value; a write in the same edge lands afterwards.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      rsp_rdata <= (!req_wr && in_range) ? regs[idx] : '0;
      rsp_err   <= !in_range;
      if (!in_range && err_count != '1) err_count <= err_count + 1'b1;
    end else if (fire) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: scoreboard bench; driver pushes model responses on accept,
// monitor pops and compares on every response fire.
module tb_reg_bank_ctrl;
  localparam int DW = 32, DEPTH = 128, AW = 8;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_wr = 0, rsp_ready = 0;
  logic [AW-1:0] req_addr = 0;
  logic [DW-1:0] req_wdata = 0;
  logic [DW/8-1:0] req_wstrb = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [7:0] err_count;

  reg_bank_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] rd; logic er; logic [7:0] ec; int cyc;} exp_t;
  exp_t q[$];
  logic [31:0] mdl [DEPTH];
  int ecnt = 0, checks = 0, failures = 0, cyc = 0, fire_cnt = 0;
  bit rand_rdy = 0;
  logic [31:0] last_rdata;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask

  // Spec-level model: registers are a plain array, errors are a capped counter.
  task automatic do_req(input bit wr, input int a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int n = 0;
    req_valid = 1; req_wr = wr; req_addr = AW'(a); req_wdata = d; req_wstrb = s;
    #1;
    while (!req_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready) chk("req_timeout", 0, 1);
    else begin
      e.rd = 0; e.er = 0; e.cyc = cyc + 1;
      if (a >= DEPTH) begin
        e.er = 1;
        if (ecnt < 255) ecnt++;
      end else if (wr) begin
        for (int k = 0; k < 4; k++) if (s[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
      end else e.rd = mdl[a];
      e.ec = 8'(ecnt);
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 1000) begin @(negedge clk); n++; end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 0;
    ecnt = 0;
    q.delete();
  endtask

  always @(negedge clk) if (rand_rdy) rsp_ready = $urandom_range(0, 3) != 0;

  bit hold = 0;
  logic [31:0] h_rd;
  logic h_er;
  exp_t m;
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      automatic bit live = q.size() > 0 && q[0].cyc <= cyc;
      chk("rsp_valid", 32'(rsp_valid), 32'(live));
      if (hold && rsp_valid) begin
        chk("hold_rdata", rsp_rdata, h_rd);
        chk("hold_err", 32'(rsp_err), 32'(h_er));
      end
      hold = rsp_valid && !rsp_ready; h_rd = rsp_rdata; h_er = rsp_err;
      if (rsp_valid && rsp_ready && live) begin
        m = q.pop_front();
        chk("rsp_rdata", rsp_rdata, m.rd);
        chk("rsp_err", 32'(rsp_err), 32'(m.er));
        chk("err_count", 32'(err_count), 32'(m.ec));
        last_rdata = rsp_rdata;
        fire_cnt++;
      end
    end else hold = 0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, f0;
    model_reset();
    #12;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err_count", 32'(err_count), 0);
    @(negedge clk);
    rst_n = 1; rsp_ready = 1;
    #1 chk("post_rst_ready", 32'(req_ready), 1);
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) do_req(0, a, 0, 0);
    drain();
    do_req(1, 5, 32'hAABBCCDD, 4'b1111);
    do_req(1, 5, 32'h11223344, 4'b0101);
    do_req(0, 5, 0, 0);
    drain();
    chk("strobe_merge", last_rdata, 32'hAA22CC44);
    do_req(0, DEPTH, 0, 0);
    drain();
    chk("err_cnt_first", 32'(err_count), 1);
    for (int i = 0; i < 259; i++) do_req(0, $urandom_range(DEPTH, 255), 0, 0);
    drain();
    chk("err_cnt_sat", 32'(err_count), 32'hFF);
    do_req(1, 20, 32'hCAFEF00D, 4'hF);
    drain();
    rsp_ready = 0;
    do_req(0, 20, 0, 0);
    req_valid = 1; req_wr = 1; req_addr = 21; req_wdata = 32'h12345678; req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_req_ready", 32'(req_ready), 0);
      chk("stall_rdata", rsp_rdata, 32'hCAFEF00D);
      @(negedge clk);
    end
    rsp_ready = 1;
    do_req(1, 21, 32'h12345678, 4'hF);
    do_req(0, 21, 0, 0);
    drain();
    c0 = cyc; f0 = fire_cnt;
    for (int i = 0; i < 8; i++) do_req(i % 2 == 0, 3, $urandom, 4'hF);
    chk("stream_cycles", cyc - c0, 8);
    drain();
    chk("stream_fires", fire_cnt - f0, 8);
    rsp_ready = 0;
    do_req(1, 0, 32'h5A, 4'hF);
    #1 chk("pre_rst_valid", 32'(rsp_valid), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1; rsp_ready = 1;
    do_req(0, 0, 0, 0);
    drain();
    chk("rst_drops_write", last_rdata, 0);
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      do_req($urandom_range(0, 1), $urandom_range(0, 140), $urandom, 4'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rand_rdy = 0;
    @(negedge clk);
    rsp_ready = 1;
    drain();
    chk("final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
